// File: rtl/trng_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trng_ctrl
// Brief    : Ring-oscillator TRNG sequencer. Warms up the oscillator bank,
//            samples the synchronized XOR of all oscillators at a fixed rate,
//            applies von Neumann debiasing, packs bits into bytes on a
//            valid/ready port and shuts the bank down on a repetition-count
//            health failure.
// Revision : 1.0 - initial release
// ============================================================================
module trng_ctrl #(
  parameter int NUM_RO        = 4,
  parameter int SAMPLE_DIV    = 8,
  parameter int WARMUP_CYCLES = 64,
  parameter int REP_LIMIT     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [NUM_RO-1:0] ro_en,
  input  logic [NUM_RO-1:0] ro_rnd,
  output logic [7:0]        data,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  // Terminal values, sized to the counters that compare against them
  localparam logic [15:0] c_warm_last = 16'(WARMUP_CYCLES - 1);
  localparam logic [7:0]  c_div_last  = 8'(SAMPLE_DIV - 1);
  localparam logic [7:0]  c_rep_limit = 8'(REP_LIMIT);

  state_t            r_state;
  state_t            w_next;
  logic [NUM_RO-1:0] r_sync1;
  logic [NUM_RO-1:0] r_sync2;
  logic [15:0]       r_warm;
  logic [7:0]        r_div;
  logic [7:0]        r_run;
  logic              r_last;
  logic              r_pair_full;
  logic              r_pair_bit;
  logic [6:0]        r_byte;
  logic [2:0]        r_nbits;

  logic w_raw;
  logic w_trip;
  logic w_sample;
  logic w_emit;
  logic w_byte_done;
  logic w_load;

  // The raw entropy bit is the parity of the synchronized oscillator bank
  assign w_raw = ^r_sync2;

  // A repetition run that reached the limit forces the shutdown path
  assign w_trip = (r_state == S_RUN) && (r_run == c_rep_limit);

  // One raw sample per divider period, only while actively generating
  assign w_sample = (r_state == S_RUN) && start && !w_trip && (r_div == c_div_last);

  // Second sample of a pair that differs from the first yields the first bit
  assign w_emit      = w_sample && r_pair_full && (r_pair_bit != w_raw);
  assign w_byte_done = w_emit && (r_nbits == 3'd7);

  // A completed byte is kept only if the output slot is (or becomes) free
  assign w_load = w_byte_done && (!valid || ready);

  assign busy  = (r_state == S_WARMUP) || (r_state == S_RUN);
  assign err   = (r_state == S_ERROR);
  assign ro_en = {NUM_RO{busy}};

  // Two-flop synchronizer for the asynchronous oscillator outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ro_rnd;
      r_sync2 <= r_sync1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; the health trip outranks a stop request
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (!start) begin
          w_next = S_IDLE;
        end else if (r_warm == c_warm_last) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_trip) begin
          w_next = S_ERROR;
        end else if (!start) begin
          w_next = S_IDLE;
        end
      end
      S_ERROR: begin
        if (err_clr) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Warm-up counter restarts on entry to WARMUP; sample divider only runs in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warm <= '0;
      r_div  <= '0;
    end else begin
      if (r_state != S_WARMUP) begin
        r_warm <= '0;
      end else if (r_warm != c_warm_last) begin
        r_warm <= r_warm + 16'd1;
      end

      if (r_state != S_RUN || r_div == c_div_last) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  // Health run counter, debias pair and partial byte; all discarded outside RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run       <= '0;
      r_last      <= 1'b0;
      r_pair_full <= 1'b0;
      r_pair_bit  <= 1'b0;
      r_byte      <= '0;
      r_nbits     <= '0;
    end else if (w_next != S_RUN) begin
      r_run       <= '0;
      r_last      <= 1'b0;
      r_pair_full <= 1'b0;
      r_pair_bit  <= 1'b0;
      r_byte      <= '0;
      r_nbits     <= '0;
    end else if (w_sample) begin
      if (r_run == 8'd0 || w_raw != r_last) begin
        r_run <= 8'd1;
      end else begin
        r_run <= r_run + 8'd1;
      end
      r_last <= w_raw;

      if (!r_pair_full) begin
        r_pair_full <= 1'b1;
        r_pair_bit  <= w_raw;
      end else begin
        r_pair_full <= 1'b0;
        if (w_emit) begin
          if (r_nbits == 3'd7) begin
            r_byte  <= '0;
            r_nbits <= '0;
          end else begin
            r_byte  <= {r_byte[5:0], r_pair_bit};
            r_nbits <= r_nbits + 3'd1;
          end
        end
      end
    end
  end

  // Output byte slot: ERROR drops the held byte, otherwise load or handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= 8'h00;
      valid <= 1'b0;
    end else if (w_next == S_ERROR) begin
      valid <= 1'b0;
    end else if (w_load) begin
      data  <= {r_byte, r_pair_bit};
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/trng_ctrl.md
# trng_ctrl

Sequencing controller for the ring-oscillator TRNG bank. Enables a set of free-running ring oscillators, synchronizes and XOR-combines their outputs, samples at a programmable rate, and applies von Neumann debiasing. Packs the debiased bits into bytes delivered over a valid/ready handshake. Runs a repetition-count health test that shuts the oscillators down on failure; sits between the oscillator instances and the byte consumer.

## Interface
- NUM_RO, 4: number of ring oscillators controlled (1..8)
- SAMPLE_DIV, 8: clocks between raw samples (2..255)
- WARMUP_CYCLES, 64: clocks the oscillators run before sampling starts (1..65535)
- REP_LIMIT, 32: consecutive identical raw samples that trigger a health failure (2..255)

- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  level; 1 = generate, 0 = stop
- ro_en  out  NUM_RO  enable to each oscillator (all bits equal)
- ro_rnd  in  NUM_RO  raw oscillator outputs, asynchronous to clk
- data  out  8  output byte
- valid  out  1  data holds a byte
- ready  in  1  consumer accepts data when valid & ready
- busy  out  1  state is WARMUP or RUN
- err  out  1  health test failed (sticky)
- err_clr  in  1  one-cycle pulse; clears err

## Operation
- Reset: state IDLE; ro_en=0, data=0x00, valid=0, busy=0, err=0; all counters, synchronizers and the pair/byte registers cleared.
- Each ro_rnd bit passes through a 2-flop synchronizer; raw bit = XOR of all synchronized bits.
- States:
  - IDLE: ro_en=0. start=1 -> WARMUP, warm-up counter loaded with 0.
  - WARMUP: ro_en all-ones. Counter increments each clock; at WARMUP_CYCLES-1 -> RUN, sample divider cleared. start=0 -> IDLE.
  - RUN: ro_en all-ones. The sample divider counts 0..SAMPLE_DIV-1; on terminal count, one raw bit is sampled. start=0 -> IDLE.
  - ERROR: ro_en=0, err=1, valid forced 0 (held byte discarded). err_clr -> IDLE. start is ignored.
- Von Neumann: the first sample of a pair is stored; on the second, 01 emits 0, 10 emits 1, 00/11 emit nothing. The pair register then empties.
- Byte assembly: byte = {byte[6:0], bit}; after 8 emitted bits, the byte is moved to data and valid is set.
- Output full (valid=1, no handshake this cycle) when a byte completes: the completed byte is discarded and assembly restarts. A handshake in the same cycle counts as empty, and the new byte loads.
- Health test: runs on every raw sample in RUN. A run counter counts consecutive identical samples (first sample = 1). Reaching REP_LIMIT -> ERROR on the next clock, regardless of the byte path.
- Leaving RUN/WARMUP for IDLE discards the pair register, the partial byte and the run counter. A byte already in data stays valid until consumed.
- err_clr outside ERROR has no effect. rst at any time returns everything to reset values within the same cycle (asynchronous).

## Timing
- ro_rnd to raw bit: 2 clocks of synchronizer latency.
- start rising edge -> busy=1 and ro_en=1 on the next clock edge.
- First raw sample: WARMUP_CYCLES + SAMPLE_DIV clocks after entering WARMUP.
- Emitted bit -> valid: the 8th emitted bit sets valid on the same edge that registers it.
- Handshake: data may change only when valid=0 or on a valid&ready edge; valid holds until accepted.
- Health trip: ro_en=0 and err=1 one clock after the REP_LIMIT-th identical sample.
- The divider, warm-up and run counters are sized for their parameter maximum with no wrap inside a state.

## Test plan
- Reset mid-RUN with valid=1: assert rst asynchronously -> ro_en=0, valid=0, data=0x00, err=0 immediately.
- NUM_RO=1, SAMPLE_DIV=2, WARMUP_CYCLES=4, ready=1; drive ro_rnd raw sequence 1,0 ×8 -> one byte data=0xFF with valid pulsed; ro_en high from start+1; first sample at cycle 6.
- Raw pairs 01,10,00,11,01,10,01,10,10,01 -> emitted bits 0,1,0,1,0,1,1,0 -> data=0x56.
- ready=0 while a second byte completes -> data keeps the first byte; the second byte is dropped. Raise ready -> the first byte is accepted; the next byte is built from fresh bits.
- REP_LIMIT=4, constant ro_rnd=0 in RUN -> after the 4th sample: state ERROR, err=1, ro_en=0, valid=0. err_clr -> IDLE, err=0. start held high -> WARMUP again.
- Drop start during WARMUP -> IDLE next clock, ro_en=0, no byte produced. Drop start in RUN with a held byte -> valid stays 1 until ready.
